// File: rtl/mod_matrix_loader_pkg.sv
// Shared constants for the 3x3 matrix loader: default width, FSM state
// encodings, element counts, the 2x2 padding value and the 2x2 slot map.
package mod_matrix_loader_pkg;

  localparam int DATA_W_DEF = 8;

  // FSM states are plain 2-bit constants so older tools can read them too.
  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] RESULT  = 2'd2;

  localparam int N3 = 9;  // elements in a 3x3 matrix
  localparam int N2 = 4;  // elements in a 2x2 matrix

  // Written to position a in 2x2 mode. With b, c, d and g cleared, the
  // 3x3 determinant then reduces to e*i - f*h.
  localparam int PAD_ONE = 1;

  // Maps 2x2 element k (row-major) onto the 3x3 slots e, f, h, i.
  function automatic logic [3:0] slot_2x2(input logic [1:0] k);
    case (k)
      2'd0:    return 4'd4;
      2'd1:    return 4'd5;
      2'd2:    return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mod_matrix_loader.sv
// Serial-to-parallel feeder for a combinational 3x3 determinant unit.
// Elements arrive one per valid/ready handshake in row-major order. The full
// matrix is then presented on a..i with mat_valid, the determinant is
// captured on mat_ready, and it is returned on a result valid/ready handshake.
// Optional: define MOD_MATRIX_LOADER_CLEAR_EN to add a 'clear' input that
// aborts back to LOAD while keeping a..i and result.
module mod_matrix_loader
  import mod_matrix_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MOD_MATRIX_LOADER_CLEAR_EN
  input  logic              clear,
`endif
  input  logic [DATA_W-1:0] elem_in,
  input  logic              elem_valid,
  output logic              elem_ready,
  input  logic              mode_2x2,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] e,
  output logic [DATA_W-1:0] f,
  output logic [DATA_W-1:0] g,
  output logic [DATA_W-1:0] h,
  output logic [DATA_W-1:0] i,
  output logic              mat_valid,
  input  logic              mat_ready,
  input  logic [DATA_W-1:0] det_in,
  output logic [DATA_W-1:0] result,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam logic [3:0] LAST3 = 4'(N3 - 1);
  localparam logic [3:0] LAST2 = 4'(N2 - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] elem_q [N3];
  logic [DATA_W-1:0] elem_d [N3];
  logic [DATA_W-1:0] result_q, result_d;

  logic mode_eff;
  logic accept;

  // Handshake outputs come straight from the state register.
  assign elem_ready = (state_q == LOAD);
  assign mat_valid  = (state_q == PRESENT);
  assign res_valid  = (state_q == RESULT);
  assign accept     = elem_valid && elem_ready;
  // mode_2x2 only counts on the first element; later it is ignored.
  assign mode_eff   = (count_q == 4'd0) ? mode_2x2 : mode_q;

  // Next-state logic: element placement, counting, FSM and result capture.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    count_d  = count_q;
    mode_d   = mode_q;
    elem_d   = elem_q;
    result_d = result_q;

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (count_q == 4'd0) mode_d = mode_2x2;
          if (mode_eff) begin
            if (count_q == 4'd0) begin
              elem_d[0] = DATA_W'(PAD_ONE);
              elem_d[1] = '0;
              elem_d[2] = '0;
              elem_d[3] = '0;
              elem_d[6] = '0;
            end
            elem_d[slot_2x2(count_q[1:0])] = elem_in;
          end else begin
            elem_d[count_q] = elem_in;
          end
          if (count_q == (mode_eff ? LAST2 : LAST3)) begin
            count_d = '0;
            state_d = PRESENT;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end
      PRESENT: begin
        if (mat_ready) begin
          result_d = det_in;
          state_d  = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase

`ifdef MOD_MATRIX_LOADER_CLEAR_EN
    // Clear wins over any same-cycle handshake but keeps a..i and result.
    if (clear) begin
      state_d  = LOAD;
      count_d  = '0;
      mode_d   = mode_q;
      elem_d   = elem_q;
      result_d = result_q;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      count_q  <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      // NOTE: the element registers drive a..i directly and must read zero
      // after reset, so this small register file is reset like any flop.
      for (int k = 0; k < N3; k++) elem_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q  <= state_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      for (int k = 0; k < N3; k++) elem_q[k] <= elem_d[k];
    end
  end

  assign a = elem_q[0];
  assign b = elem_q[1];
  assign c = elem_q[2];
  assign d = elem_q[3];
  assign e = elem_q[4];
  assign f = elem_q[5];
  assign g = elem_q[6];
  assign h = elem_q[7];
  assign i = elem_q[8];
  assign result = result_q;

endmodule

// File: tb/tb_mod_matrix_loader.sv
// Directed self-checking bench for mod_matrix_loader. The bench plays the
// determinant unit with its own 3x3 determinant model and compares against
// hand-computed matrices and determinants.
module tb_mod_matrix_loader;

  typedef logic [8:0][7:0] mat_t;  // index 0 = a ... index 8 = i

  logic       clk = 1'b0;
  logic       reset;
`ifdef MOD_MATRIX_LOADER_CLEAR_EN
  logic       clear;
`endif
  logic [7:0] elem_in;
  logic       elem_valid;
  logic       elem_ready;
  logic       mode_2x2;
  logic [7:0] a, b, c, d, e, f, g, h, i;
  logic       mat_valid;
  logic       mat_ready;
  logic [7:0] det_in;
  logic [7:0] result;
  logic       res_valid;
  logic       res_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_matrix_loader #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MOD_MATRIX_LOADER_CLEAR_EN
    .clear      (clear),
`endif
    .elem_in    (elem_in),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .mode_2x2   (mode_2x2),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .mat_valid  (mat_valid),
    .mat_ready  (mat_ready),
    .det_in     (det_in),
    .result     (result),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  mat_t dut_m;
  assign dut_m = {i, h, g, f, e, d, c, b, a};

  // Reference determinant unit, modulo 256.
  function automatic logic [7:0] det3(input mat_t m);
    int r;
    r = int'(m[0]) * (int'(m[4]) * int'(m[8]) - int'(m[5]) * int'(m[7]))
      - int'(m[1]) * (int'(m[3]) * int'(m[8]) - int'(m[5]) * int'(m[6]))
      + int'(m[2]) * (int'(m[3]) * int'(m[7]) - int'(m[4]) * int'(m[6]));
    return r[7:0];
  endfunction

  assign det_in = det3(dut_m);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mat(input string tag, input mat_t exp);
    for (int k = 0; k < 9; k++) check($sformatf("%s_elem%0d", tag, k), dut_m[k], exp[k]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_mat(tag, '0);
    check({tag, "_result"}, result, 0);
    check({tag, "_mat_valid"}, mat_valid, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_elem_ready"}, elem_ready, 1);
  endtask

  // Streams the first n entries of v (row-major). mode_2x2 is m2 on the
  // first element and inverted afterwards to show it is ignored. With gaps,
  // an idle cycle carrying junk data follows each accept.
  task automatic load_elems(input mat_t v, input int n, input bit m2, input bit gaps);
    for (int k = 0; k < n; k++) begin
      elem_in    = v[k];
      elem_valid = 1'b1;
      mode_2x2   = (k == 0) ? m2 : ~m2;
      check($sformatf("ready_before_accept%0d", k), elem_ready, 1);
      if (k == n - 1) check("mat_valid_before_last", mat_valid, 0);
      tick();
      elem_valid = 1'b0;
      if (gaps && k != n - 1) begin
        elem_in  = 8'hEE;
        mode_2x2 = ~m2;
        tick();
      end
    end
    elem_valid = 1'b0;
    mode_2x2   = 1'b0;
  endtask

  // Called the cycle after the last accept: checks presentation, delays
  // mat_ready and res_ready, and checks the returned determinant.
  task automatic finish_matrix(input string tag, input mat_t exp_m, input logic [7:0] exp_det,
                               input int mat_dly, input int res_dly);
    check({tag, "_mat_valid_rise"}, mat_valid, 1);
    check({tag, "_elem_ready_present"}, elem_ready, 0);
    check_mat(tag, exp_m);
    for (int k = 0; k < mat_dly; k++) begin
      tick();
      check({tag, "_mat_valid_hold"}, mat_valid, 1);
      check_mat({tag, "_hold"}, exp_m);
    end
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_mat_valid_drop"}, mat_valid, 0);
    check({tag, "_elem_ready_result"}, elem_ready, 0);
    check({tag, "_result"}, result, exp_det);
    for (int k = 0; k < res_dly; k++) begin
      tick();
      check({tag, "_res_valid_hold"}, res_valid, 1);
      check({tag, "_result_hold"}, result, exp_det);
      check({tag, "_elem_ready_hold"}, elem_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, res_valid, 0);
    check({tag, "_elem_ready_back"}, elem_ready, 1);
    check_mat({tag, "_after"}, exp_m);
  endtask

  initial begin
    mat_t m;
    reset      = 1'b1;
`ifdef MOD_MATRIX_LOADER_CLEAR_EN
    clear      = 1'b0;
`endif
    elem_in    = '0;
    elem_valid = 1'b0;
    mode_2x2   = 1'b0;
    mat_ready  = 1'b0;
    res_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Back-to-back 1..9: determinant of that matrix is 0.
    m = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load_elems(m, 9, 1'b0, 1'b0);
    finish_matrix("seq", m, 8'd0, 0, 0);

    // Diagonal 2,3,4: determinant 24.
    m = {8'd4, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd2};
    load_elems(m, 9, 1'b0, 1'b0);
    finish_matrix("diag", m, 8'd24, 1, 1);

    // 2x2 [[3,1],[2,5]]: padded matrix, determinant 15-2 = 13.
    m = {8'd5, 8'd2, 8'd0, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd1};
    load_elems({8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'd5, 8'd2, 8'd1, 8'd3}, 4, 1'b1, 1'b0);
    finish_matrix("m2x2", m, 8'd13, 0, 0);

    // Backpressure: [[1,2,3],[4,5,6],[7,8,10]], det = -3 = 0xFD.
    m = {8'd10, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load_elems(m, 9, 1'b0, 1'b1);
    finish_matrix("bp", m, 8'hFD, 5, 3);

    // Reset after 5 accepts, then a fresh matrix
    // [[2,1,0],[1,3,1],[0,1,4]], det = 2*11 - 1*4 = 18.
    load_elems({8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9}, 5, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("midreset");
    m = {8'd4, 8'd1, 8'd0, 8'd1, 8'd3, 8'd1, 8'd0, 8'd1, 8'd2};
    load_elems(m, 9, 1'b0, 1'b0);
    finish_matrix("postreset", m, 8'd18, 0, 0);

`ifdef MOD_MATRIX_LOADER_CLEAR_EN
    // Clear in PRESENT together with mat_ready: clear wins, data kept.
    load_elems(m, 9, 1'b0, 1'b0);
    check("clr_mat_valid_pre", mat_valid, 1);
    clear     = 1'b1;
    mat_ready = 1'b1;
    tick();
    clear     = 1'b0;
    mat_ready = 1'b0;
    check("clr_mat_valid", mat_valid, 0);
    check("clr_res_valid", res_valid, 0);
    check("clr_elem_ready", elem_ready, 1);
    check("clr_result_kept", result, 8'd18);
    check_mat("clr_kept", m);
    load_elems({8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h77}, 1, 1'b0, 1'b0);
    check("clr_first_to_a", a, 8'h77);
    check("clr_b_kept", b, 8'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
